// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard controller: scoreboard entry
// layout, forwarding source codes and the func codes that identify loads.
package hazard_pkg;

  localparam int HZ_ENT_W = 7;

  // Forwarding source select: register file, or the result held in entry k.
  localparam logic [1:0] HZ_FWD_RF = 2'd0;
  localparam logic [1:0] HZ_FWD_E0 = 2'd1;
  localparam logic [1:0] HZ_FWD_E1 = 2'd2;
  localparam logic [1:0] HZ_FWD_E2 = 2'd3;

  localparam logic [5:0] FN_ADD  = 6'd0;
  localparam logic [5:0] FN_SUB  = 6'd1;
  localparam logic [5:0] FN_ADDI = 6'd8;
  localparam logic [5:0] FN_LB   = 6'd16;
  localparam logic [5:0] FN_LH   = 6'd17;
  localparam logic [5:0] FN_LW   = 6'd18;
  localparam logic [5:0] FN_LBU  = 6'd19;
  localparam logic [5:0] FN_LHU  = 6'd20;
  localparam logic [5:0] FN_SW   = 6'd24;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       ld;
  } hz_ent_t;

  function automatic logic is_load(input logic [5:0] func);
    return func inside {FN_LB, FN_LH, FN_LW, FN_LBU, FN_LHU};
  endfunction

endpackage

// File: rtl/hazard_sb.sv
// Shift scoreboard of destination registers in flight after decode
// (entry 0 = EX ... DEPTH-1 = WB) with per-entry source match vectors.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [4:0]       issue_rd,
  input  logic             issue_ld,
  input  logic [4:0]       rs1,
  input  logic             rs1v,
  input  logic [4:0]       rs2,
  input  logic             rs2v,
  output logic [DEPTH-1:0] m1,
  output logic [DEPTH-1:0] m2,
  output logic             ld_hit
);

  hz_ent_t ent_q [DEPTH];

  // Entries advance every cycle regardless of stall; a stall simply issues a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
    end else begin
      ent_q[0] <= issue ? hz_ent_t'{1'b1, issue_rd, issue_ld} : hz_ent_t'('0);
      for (int k = 1; k < DEPTH; k++) ent_q[k] <= ent_q[k-1];
    end
  end

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m1[k] = rs1v && (rs1 != 5'd0) && ent_q[k].vld && (ent_q[k].rd == rs1);
      m2[k] = rs2v && (rs2 != 5'd0) && ent_q[k].vld && (ent_q[k].rd == rs2);
    end
    ld_hit = ent_q[0].vld && ent_q[0].ld && (m1[0] || m2[0]);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: stall/jmp generation, flush sequencing and
// optional operand forwarding select (enabled by defining HAZARD_FWD_EN).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_rs1v,
  input  logic       id_rs2v,
  input  logic       id_rdv,
  input  logic [5:0] id_func,
  input  logic       br_taken,
  output logic       stall,
  output logic       jmp,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic [2:0]       fcnt;
  logic [DEPTH-1:0] m1;
  logic [DEPTH-1:0] m2;
  logic             ld_hit;
  logic             issue;

  // A redirect reloads the count, so a second branch mid-flush restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt <= 3'd0;
    end else if (br_taken) begin
      fcnt <= 3'(FLUSH_CYCLES - 1);
    end else if (fcnt != 3'd0) begin
      fcnt <= fcnt - 3'd1;
    end
  end

  assign jmp   = br_taken | (fcnt != 3'd0);
  assign issue = !stall && !jmp && id_rdv && (id_rd != 5'd0);

  hazard_sb #(
    .DEPTH (DEPTH)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .issue_rd (id_rd),
    .issue_ld (is_load(id_func)),
    .rs1      (id_rs1),
    .rs1v     (id_rs1v),
    .rs2      (id_rs2),
    .rs2v     (id_rs2v),
    .m1       (m1),
    .m2       (m2),
    .ld_hit   (ld_hit)
  );

`ifdef HAZARD_FWD_EN
  // Youngest matching entry wins: scan oldest to youngest, last hit sticks.
  function automatic logic [1:0] youngest(input logic [DEPTH-1:0] m);
    logic [1:0] sel;
    sel = HZ_FWD_RF;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (m[k]) sel = 2'(k + 1);
    end
    return sel;
  endfunction

  always_comb begin
    stall = !jmp && ld_hit;
    fwd_a = HZ_FWD_RF;
    fwd_b = HZ_FWD_RF;
    if (!jmp && !ld_hit) begin
      fwd_a = youngest(m1);
      fwd_b = youngest(m2);
    end
  end
`else
  // ld_hit is a subset of m1[0]|m2[0]; without forwarding every match stalls.
  always_comb begin
    stall = !jmp && ((|m1) || (|m2) || ld_hit);
    fwd_a = HZ_FWD_RF;
    fwd_b = HZ_FWD_RF;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow HAZARD_FWD_EN when defined.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic [4:0] id_rd = '0;
  logic       id_rs1v = 1'b0;
  logic       id_rs2v = 1'b0;
  logic       id_rdv = 1'b0;
  logic [5:0] id_func = FN_ADD;
  logic       br_taken = 1'b0;
  logic       stall;
  logic       jmp;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  int total = 0;
  int bad = 0;

  // Expected {stall, jmp, fwd_a, fwd_b} per driven cycle.
  logic [5:0] exp_q[$];
  string      tag_q[$];

  localparam logic [5:0] OK  = 6'b00_0000;
  localparam logic [5:0] STL = 6'b10_0000;
  localparam logic [5:0] JMP = 6'b01_0000;

  logic [4:0] r;
  logic [4:0] o;
  logic [4:0] b;

  hazard_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .id_rs1   (id_rs1),
    .id_rs2   (id_rs2),
    .id_rd    (id_rd),
    .id_rs1v  (id_rs1v),
    .id_rs2v  (id_rs2v),
    .id_rdv   (id_rdv),
    .id_func  (id_func),
    .br_taken (br_taken),
    .stall    (stall),
    .jmp      (jmp),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b ({stall,jmp,fwd_a,fwd_b} or scalar)", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] fw(input logic [1:0] fa, input logic [1:0] fb);
    return {2'b00, fa, fb};
  endfunction

  // v = {rs1v, rs2v, rdv}
  task automatic cyc(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic [2:0] v, input logic [5:0] func,
                     input logic br, input logic [5:0] exp);
    @(posedge clk);
    #1;
    id_rs1 = rs1;
    id_rs2 = rs2;
    id_rd  = rd;
    {id_rs1v, id_rs2v, id_rdv} = v;
    id_func  = func;
    br_taken = br;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc("nop", 5'd0, 5'd0, 5'd0, 3'b000, FN_ADD, 1'b0, OK);
  endtask

  task automatic set_nop();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    {id_rs1v, id_rs2v, id_rdv} = 3'b000;
    id_func = FN_ADD;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) check(tag_q.pop_front(), {2'b00, stall, jmp, fwd_a, fwd_b}, {2'b00, exp_q.pop_front()});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with br_taken asserted in the reset cycle; it must be ignored.
    @(posedge clk); #1;
    rst = 1'b1; br_taken = 1'b1; set_nop();
    @(posedge clk); #1;
    rst = 1'b0; br_taken = 1'b0;
    exp_q.push_back(OK); tag_q.push_back("post_rst");
    drain(1);

    for (int it = 0; it < 2; it++) begin
      // Scenario 1: ALU producer then consumer back to back.
      r = (it == 0) ? 5'd5 : 5'($urandom_range(1, 31));
      o = 5'((r % 31) + 1);
      cyc("s1_addi", 5'd0, 5'd0, r, 3'b101, FN_ADDI, 1'b0, OK);
`ifdef HAZARD_FWD_EN
      cyc("s1_add_fwd", r, r, o, 3'b111, FN_ADD, 1'b0, fw(2'd1, 2'd1));
`else
      cyc("s1_stall0", r, r, o, 3'b111, FN_ADD, 1'b0, STL);
      cyc("s1_stall1", r, r, o, 3'b111, FN_ADD, 1'b0, STL);
      cyc("s1_stall2", r, r, o, 3'b111, FN_ADD, 1'b0, STL);
      cyc("s1_issue",  r, r, o, 3'b111, FN_ADD, 1'b0, OK);
`endif
      drain(3);

      // Scenario 2: load then dependent use.
      r = (it == 0) ? 5'd7 : 5'($urandom_range(2, 31));
      o = 5'((r % 31) + 1);
      b = (r == 5'd1) ? 5'd2 : 5'd1;
      cyc("s2_lw", 5'd1, 5'd0, r, 3'b101, FN_LW, 1'b0, OK);
`ifdef HAZARD_FWD_EN
      cyc("s2_lu_stall", r, b, o, 3'b111, FN_ADD, 1'b0, STL);
      cyc("s2_fwd",      r, b, o, 3'b111, FN_ADD, 1'b0, fw(2'd2, 2'd0));
`else
      cyc("s2_stall0", r, b, o, 3'b111, FN_ADD, 1'b0, STL);
      cyc("s2_stall1", r, b, o, 3'b111, FN_ADD, 1'b0, STL);
      cyc("s2_stall2", r, b, o, 3'b111, FN_ADD, 1'b0, STL);
      cyc("s2_issue",  r, b, o, 3'b111, FN_ADD, 1'b0, OK);
`endif
      drain(3);
    end

    // Two writers of x5 in a row: the younger one is the source.
    cyc("y_a", 5'd0, 5'd0, 5'd5, 3'b101, FN_ADDI, 1'b0, OK);
    cyc("y_b", 5'd0, 5'd0, 5'd5, 3'b101, FN_ADDI, 1'b0, OK);
`ifdef HAZARD_FWD_EN
    cyc("y_use", 5'd5, 5'd0, 5'd9, 3'b101, FN_ADDI, 1'b0, fw(2'd1, 2'd0));
`else
    cyc("y_stall0", 5'd5, 5'd0, 5'd9, 3'b101, FN_ADDI, 1'b0, STL);
    cyc("y_stall1", 5'd5, 5'd0, 5'd9, 3'b101, FN_ADDI, 1'b0, STL);
    cyc("y_stall2", 5'd5, 5'd0, 5'd9, 3'b101, FN_ADDI, 1'b0, STL);
    cyc("y_issue",  5'd5, 5'd0, 5'd9, 3'b101, FN_ADDI, 1'b0, OK);
`endif
    drain(3);

    // Scenario 3: writes to x0 never enter the scoreboard.
    cyc("s3_add_x0", 5'd1, 5'd2, 5'd0, 3'b111, FN_ADD, 1'b0, OK);
    cyc("s3_read_x0", 5'd0, 5'd0, 5'd3, 3'b111, FN_ADD, 1'b0, OK);
    @(negedge clk);
    check("s3_e0_vld", 8'(dut.u_sb.ent_q[0].vld), 8'd0);
    drain(3);

    // Scenario 4: flush length, nothing issues under jmp, restart extends.
    cyc("s4_br",    5'd0, 5'd0, 5'd9,  3'b101, FN_ADDI, 1'b1, JMP);
    cyc("s4_jmp2",  5'd0, 5'd0, 5'd10, 3'b101, FN_ADDI, 1'b0, JMP);
    cyc("s4_after", 5'd9, 5'd10, 5'd11, 3'b111, FN_ADD, 1'b0, OK);
    drain(3);
    cyc("s4x_br",   5'd0, 5'd0, 5'd12, 3'b101, FN_ADDI, 1'b1, JMP);
    cyc("s4x_br2",  5'd0, 5'd0, 5'd12, 3'b101, FN_ADDI, 1'b1, JMP);
    cyc("s4x_jmp3", 5'd0, 5'd0, 5'd12, 3'b101, FN_ADDI, 1'b0, JMP);
    cyc("s4x_end",  5'd12, 5'd12, 5'd13, 3'b111, FN_ADD, 1'b0, OK);
    drain(3);

    // Scenario 5: load-use coinciding with a taken branch.
    cyc("s5_lw",    5'd1, 5'd0, 5'd13, 3'b101, FN_LW, 1'b0, OK);
    cyc("s5_lu_br", 5'd13, 5'd13, 5'd14, 3'b111, FN_ADD, 1'b1, JMP);
    cyc("s5_jmp2",  5'd14, 5'd0, 5'd15, 3'b111, FN_ADD, 1'b0, JMP);
    cyc("s5_no_14", 5'd14, 5'd14, 5'd16, 3'b111, FN_ADD, 1'b0, OK);
    drain(3);

    // Scenario 6: reset mid-flush with live entries.
    cyc("s6_a",  5'd0, 5'd0, 5'd17, 3'b101, FN_ADDI, 1'b0, OK);
    cyc("s6_b",  5'd0, 5'd0, 5'd18, 3'b101, FN_ADDI, 1'b0, OK);
    cyc("s6_br", 5'd0, 5'd0, 5'd0,  3'b000, FN_ADD,  1'b1, JMP);
    @(posedge clk); #1;
    rst = 1'b1; br_taken = 1'b0; set_nop();
    @(posedge clk); #1;
    rst = 1'b0;
    id_rs1 = 5'd18; id_rs2 = 5'd17; id_rd = 5'd19;
    {id_rs1v, id_rs2v, id_rdv} = 3'b111;
    id_func = FN_ADD;
    exp_q.push_back(OK); tag_q.push_back("s6_post_rst");
`ifdef HAZARD_FWD_EN
    cyc("s6_dep", 5'd19, 5'd0, 5'd20, 3'b101, FN_ADDI, 1'b0, fw(2'd1, 2'd0));
`else
    cyc("s6_dep", 5'd19, 5'd0, 5'd20, 3'b101, FN_ADDI, 1'b0, STL);
`endif
    drain(4);

    @(negedge clk); #1;
    check("q_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
